systolic_mm_seq: RTL and testbench

- Sequencer for the 3x3 systolic matrix-multiply array (5 A lanes, 5 B lanes, 5 result taps).
- Latches two row-major 3x3 operand sets on a start handshake, clears the array accumulators and drives the skewed feed over 3 cycles.
- Waits the array latency, captures the 9 results from the taps over 3 cycles, then presents them with a valid/ready handshake.
- Sits between the host or register interface and the PE/delay-element array.

---
 rtl/mm_pkg.sv | 29 ++
 rtl/mm_skew_feeder.sv | 78 +++++++
 rtl/systolic_mm_seq.sv | 202 ++++++++++++++++++++
 tb/tb_systolic_mm_seq.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the 3x3 systolic matrix-multiply sequencer.
// Optional feature macro used by the top: MM_PERF_CNT_EN.
package mm_pkg;

    localparam int LANES  = 5;
    localparam int MAT_N  = 9;
    localparam int DW_DEF = 8;
    localparam int RW_DEF = 18;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLR     = 3'd1,
        FEED    = 3'd2,
        DRAIN   = 3'd3,
        COLLECT = 3'd4,
        DONE    = 3'd5
    } mm_state_e;

    // Tap index feeding each result element, c0 in the low field (3 bits per element).
    // c0..c8 <- T0,T1,T2,T3,T0,T1,T4,T3,T0
    localparam logic [26:0] TAP_MAP = {3'd0, 3'd3, 3'd4, 3'd1, 3'd0,
                                       3'd3, 3'd2, 3'd1, 3'd0};

    // Collect cycle in which each result element is captured (2 bits per element).
    // c0..c8 captured in cycles 0,0,0,0,1,1,0,1,2
    localparam logic [17:0] COLLECT_MAP = {2'd2, 2'd1, 2'd0, 2'd1, 2'd1,
                                           2'd0, 2'd0, 2'd0, 2'd0};

endpackage

// File: rtl/mm_skew_feeder.sv
// Registered skewed-lane generator: presents the diagonal wavefronts of A
// and B on the five array lanes during the three feed cycles.
module mm_skew_feeder
    import mm_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [MAT_N*DW-1:0]   a_op,
    input  logic [MAT_N*DW-1:0]   b_op,
    input  logic                  feed,
    input  logic [1:0]            cyc,
    output logic [LANES*DW-1:0]   a_lane,
    output logic [LANES*DW-1:0]   b_lane
);

    logic [LANES*DW-1:0] a_nxt_s;
    logic [LANES*DW-1:0] b_nxt_s;
    logic [LANES*DW-1:0] a_lane_r;
    logic [LANES*DW-1:0] b_lane_r;

    // Select the wavefront for the upcoming cycle (feed/cyc describe the next cycle)
    always_comb begin
        a_nxt_s = '0;
        b_nxt_s = '0;
        if (feed) begin
            case (cyc)
                2'd0: begin
                    a_nxt_s[0*DW +: DW] = a_op[0*DW +: DW];
                    a_nxt_s[1*DW +: DW] = a_op[1*DW +: DW];
                    a_nxt_s[2*DW +: DW] = a_op[2*DW +: DW];
                    b_nxt_s[0*DW +: DW] = b_op[0*DW +: DW];
                    b_nxt_s[1*DW +: DW] = b_op[3*DW +: DW];
                    b_nxt_s[2*DW +: DW] = b_op[6*DW +: DW];
                end
                2'd1: begin
                    a_nxt_s[1*DW +: DW] = a_op[3*DW +: DW];
                    a_nxt_s[2*DW +: DW] = a_op[4*DW +: DW];
                    a_nxt_s[3*DW +: DW] = a_op[5*DW +: DW];
                    b_nxt_s[1*DW +: DW] = b_op[1*DW +: DW];
                    b_nxt_s[2*DW +: DW] = b_op[4*DW +: DW];
                    b_nxt_s[3*DW +: DW] = b_op[7*DW +: DW];
                end
                2'd2: begin
                    a_nxt_s[2*DW +: DW] = a_op[6*DW +: DW];
                    a_nxt_s[3*DW +: DW] = a_op[7*DW +: DW];
                    a_nxt_s[4*DW +: DW] = a_op[8*DW +: DW];
                    b_nxt_s[2*DW +: DW] = b_op[2*DW +: DW];
                    b_nxt_s[3*DW +: DW] = b_op[5*DW +: DW];
                    b_nxt_s[4*DW +: DW] = b_op[8*DW +: DW];
                end
                default: begin
                    a_nxt_s = '0;
                    b_nxt_s = '0;
                end
            endcase
        end else begin
            a_nxt_s = '0;
            b_nxt_s = '0;
        end
    end

    // Lane registers so the array sees clean, glitch-free operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_lane_r <= '0;
            b_lane_r <= '0;
        end else begin
            a_lane_r <= a_nxt_s;
            b_lane_r <= b_nxt_s;
        end
    end

    assign a_lane = a_lane_r;
    assign b_lane = b_lane_r;

endmodule

// File: rtl/systolic_mm_seq.sv
// Sequencer for the 3x3 systolic matrix-multiply array: latches operands on
// start, clears the accumulators, feeds skewed lanes, waits the array
// latency, captures the nine results from the taps and hands them out with
// a valid/ready handshake.
// Optional feature: define MM_PERF_CNT_EN to add op_cnt/stall_cnt outputs.
module systolic_mm_seq
    import mm_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int RW          = RW_DEF,
    parameter int COLLECT_LAT = 6      // legal range 3..15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [MAT_N*DW-1:0]   a_in,
    input  logic [MAT_N*DW-1:0]   b_in,
    output logic                  busy,
    output logic                  acc_clr,
    output logic [LANES*DW-1:0]   a_lane,
    output logic [LANES*DW-1:0]   b_lane,
    input  logic [LANES*RW-1:0]   tap,
    output logic [MAT_N*RW-1:0]   c_out,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef MM_PERF_CNT_EN
    ,
    output logic [15:0]           op_cnt,
    output logic [15:0]           stall_cnt
`endif
);

    localparam logic [3:0] LAT_C = 4'(COLLECT_LAT);

    mm_state_e             state_r;
    mm_state_e             state_nxt_s;
    logic [3:0]            cyc_r;
    logic [3:0]            cyc_nxt_s;
    logic [3:0]            cyc_inc_s;
    logic                  load_s;
    logic [MAT_N*DW-1:0]   a_op_r;
    logic [MAT_N*DW-1:0]   b_op_r;
    logic [MAT_N*RW-1:0]   c_r;
    logic                  busy_r;
    logic                  acc_clr_r;
    logic                  out_valid_r;

    assign cyc_inc_s = cyc_r + 4'd1;

    // Next-state and cycle-counter logic; cyc counts from the first feed
    // cycle and is reused as the collect index after restarting at zero
    always_comb begin
        state_nxt_s = state_r;
        cyc_nxt_s   = cyc_r;
        load_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = CLR;
                    cyc_nxt_s   = 4'd0;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CLR: begin
                state_nxt_s = FEED;
                cyc_nxt_s   = 4'd0;
            end
            FEED: begin
                cyc_nxt_s = cyc_inc_s;
                if (cyc_r == 4'd2) begin
                    // minimum latency goes straight from the last feed to collect
                    if (cyc_inc_s == LAT_C) begin
                        state_nxt_s = COLLECT;
                        cyc_nxt_s   = 4'd0;
                    end else begin
                        state_nxt_s = DRAIN;
                    end
                end else begin
                    state_nxt_s = FEED;
                end
            end
            DRAIN: begin
                cyc_nxt_s = cyc_inc_s;
                if (cyc_inc_s == LAT_C) begin
                    state_nxt_s = COLLECT;
                    cyc_nxt_s   = 4'd0;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            COLLECT: begin
                cyc_nxt_s = cyc_inc_s;
                if (cyc_r == 4'd2) begin
                    state_nxt_s = DONE;
                    cyc_nxt_s   = 4'd0;
                end else begin
                    state_nxt_s = COLLECT;
                end
            end
            DONE: begin
                // start in the same cycle is deliberately not looked at here
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cyc_nxt_s   = 4'd0;
            end
        endcase
    end

    // State, counter and registered status outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cyc_r       <= 4'd0;
            busy_r      <= 1'b0;
            acc_clr_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cyc_r       <= cyc_nxt_s;
            busy_r      <= (state_nxt_s != IDLE);
            acc_clr_r   <= (state_nxt_s == CLR);
            out_valid_r <= (state_nxt_s == DONE);
        end
    end

    // Operand latch so the host may change a_in/b_in right after start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_op_r <= '0;
            b_op_r <= '0;
        end else if (load_s) begin
            a_op_r <= a_in;
            b_op_r <= b_in;
        end
    end

    // Capture taps into the result matrix; c_out otherwise holds its last value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_r <= '0;
        end else if (state_r == COLLECT) begin
            for (int i = 0; i < MAT_N; i++) begin
                if (COLLECT_MAP[i*2 +: 2] == cyc_r[1:0]) begin
                    c_r[i*RW +: RW] <= tap[int'(TAP_MAP[i*3 +: 3])*RW +: RW];
                end
            end
        end
    end

    mm_skew_feeder #(
        .DW (DW)
    ) u_feeder (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_op   (a_op_r),
        .b_op   (b_op_r),
        .feed   (state_nxt_s == FEED),
        .cyc    (cyc_nxt_s[1:0]),
        .a_lane (a_lane),
        .b_lane (b_lane)
    );

    assign busy      = busy_r;
    assign acc_clr   = acc_clr_r;
    assign out_valid = out_valid_r;
    assign c_out     = c_r;

`ifdef MM_PERF_CNT_EN
    logic [15:0] op_cnt_r;
    logic [15:0] stall_cnt_r;

    // Saturating counters of completed handshakes and back-pressured DONE cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt_r    <= 16'd0;
            stall_cnt_r <= 16'd0;
        end else if (state_r == DONE) begin
            if (out_ready) begin
                if (op_cnt_r != 16'hFFFF) begin
                    op_cnt_r <= op_cnt_r + 16'd1;
                end
            end else begin
                if (stall_cnt_r != 16'hFFFF) begin
                    stall_cnt_r <= stall_cnt_r + 16'd1;
                end
            end
        end
    end

    assign op_cnt    = op_cnt_r;
    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_systolic_mm_seq.sv
// Self-checking bench for systolic_mm_seq: scoreboard of expected result
// matrices, per-cycle lane/clear model, back-pressure, ignored starts,
// asynchronous abort and a latency sweep over three instances.
module tb_systolic_mm_seq;

    localparam int DW = 8;
    localparam int RW = 18;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              start_sw;
    logic [9*DW-1:0]   a_in;
    logic [9*DW-1:0]   b_in;
    logic [5*RW-1:0]   tap;
    logic              out_ready;

    logic              busy, acc_clr, out_valid;
    logic [5*DW-1:0]   a_lane, b_lane;
    logic [9*RW-1:0]   c_out;

    logic              busy3, clr3, valid3;
    logic [5*DW-1:0]   al3, bl3;
    logic [9*RW-1:0]   c3;
    logic              busy10, clr10, valid10;
    logic [5*DW-1:0]   al10, bl10;
    logic [9*RW-1:0]   c10;
`ifdef MM_PERF_CNT_EN
    logic [15:0] op_cnt, stall_cnt, op3, st3, op10, st10;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_no  = 0;
    int feed0   = -100;
    bit track   = 1'b0;
    logic [9*DW-1:0] exp_a, exp_b;
    logic [9*RW-1:0] sb[$];
    int exp_ops   = 0;
    int exp_stall = 0;

    systolic_mm_seq #(.DW(DW), .RW(RW), .COLLECT_LAT(6)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
        .busy(busy), .acc_clr(acc_clr), .a_lane(a_lane), .b_lane(b_lane),
        .tap(tap), .c_out(c_out), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MM_PERF_CNT_EN
        , .op_cnt(op_cnt), .stall_cnt(stall_cnt)
`endif
    );

    systolic_mm_seq #(.DW(DW), .RW(RW), .COLLECT_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .start(start_sw), .a_in(a_in), .b_in(b_in),
        .busy(busy3), .acc_clr(clr3), .a_lane(al3), .b_lane(bl3),
        .tap(tap), .c_out(c3), .out_valid(valid3), .out_ready(1'b1)
`ifdef MM_PERF_CNT_EN
        , .op_cnt(op3), .stall_cnt(st3)
`endif
    );

    systolic_mm_seq #(.DW(DW), .RW(RW), .COLLECT_LAT(10)) u_lat10 (
        .clk(clk), .rst_n(rst_n), .start(start_sw), .a_in(a_in), .b_in(b_in),
        .busy(busy10), .acc_clr(clr10), .a_lane(al10), .b_lane(bl10),
        .tap(tap), .c_out(c10), .out_valid(valid10), .out_ready(1'b1)
`ifdef MM_PERF_CNT_EN
        , .op_cnt(op10), .stall_cnt(st10)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index used as the time base for stimulus and expectations
    always @(posedge clk) cyc_no <= cyc_no + 1;

    // Array stand-in: tap j reads 100*(cycles since first feed)+j
    always_comb begin
        tap = '0;
        for (int j = 0; j < 5; j++) tap[j*RW +: RW] = RW'((cyc_no - feed0) * 100 + j);
    end

    task automatic check_val(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected result for a given latency, built from the published capture map
    function automatic logic [9*RW-1:0] exp_c(input int lat);
        int tap_of[9] = '{0, 1, 2, 3, 0, 1, 4, 3, 0};
        int k_of[9]   = '{0, 0, 0, 0, 1, 1, 0, 1, 2};
        logic [9*RW-1:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) r[i*RW +: RW] = RW'(100 * (lat + k_of[i]) + tap_of[i]);
        return r;
    endfunction

    function automatic logic [9*DW-1:0] rnd_mat();
        logic [9*DW-1:0] m;
        for (int i = 0; i < 9; i++) m[i*DW +: DW] = DW'($urandom_range(1, 255));
        return m;
    endfunction

    logic [5*DW-1:0] ea, eb;
    int kk, rr;
    // Per-cycle lane/clear model and scoreboard pop on each handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (track) begin
                kk = cyc_no - feed0;
                ea = '0;
                eb = '0;
                if (kk >= 0 && kk <= 2) begin
                    for (int j = 0; j < 5; j++) begin
                        rr = j - kk;
                        if (rr >= 0 && rr <= 2) begin
                            ea[j*DW +: DW] = exp_a[(kk*3 + rr)*DW +: DW];
                            eb[j*DW +: DW] = exp_b[(rr*3 + kk)*DW +: DW];
                        end
                    end
                end
                check_val("a_lane", a_lane, ea);
                check_val("b_lane", b_lane, eb);
                check_val("acc_clr", acc_clr, (cyc_no == feed0 - 1));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check_val("sb_extra", 1, 0);
                else check_val("c_out", c_out, sb.pop_front());
            end
        end
    end

    task automatic wait_valid(input int max, output int vc);
        vc = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (out_valid) begin
                vc = cyc_no;
                break;
            end
        end
        if (vc < 0) check_val("valid_timeout", 0, 1);
    endtask

    task automatic run_op(input logic [9*DW-1:0] a, input logic [9*DW-1:0] b,
                          input bit stall, input bit poke);
        int v;
        logic [9*RW-1:0] snap;
        @(posedge clk); #1;
        a_in = a; b_in = b; start = 1'b1;
        exp_a = a; exp_b = b;
        feed0 = cyc_no + 2;
        track = 1'b1;
        sb.push_back(exp_c(6));
        if (stall) out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; a_in = rnd_mat(); b_in = rnd_mat();
        if (poke) begin
            @(posedge clk); #1;            // first feed cycle
            @(posedge clk); #1; start = 1'b1;  // FEED cyc1
            @(posedge clk); #1; start = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1; start = 1'b1;  // DRAIN
            @(posedge clk); #1; start = 1'b0;
        end
        wait_valid(40, v);
        check_val("valid_rise", v, feed0 + 9);
        if (stall) begin
            snap = c_out;
            for (int i = 0; i < 5; i++) begin
                if (i > 0) @(negedge clk);
                check_val("bp_valid", out_valid, 1);
                check_val("bp_hold", c_out, snap);
            end
            @(posedge clk); #1;
            out_ready = 1'b1; start = 1'b1;   // start collides with the handshake
            exp_stall += 5;
        end
        exp_ops++;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_val("post_valid", out_valid, 0);
        check_val("post_busy", busy, 0);
        check_val("c_hold", c_out, exp_c(6));
        track = 1'b0;
        if (poke) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check_val("poke_idle", busy, 0);
            end
        end
`ifdef MM_PERF_CNT_EN
        check_val("op_cnt", op_cnt, 16'(exp_ops));
        check_val("stall_cnt", stall_cnt, 16'(exp_stall));
`endif
    endtask

    logic [9*DW-1:0] seq_a, seq_b;
    int v3, v10;

    initial begin
        rst_n = 1'b0; start = 1'b0; start_sw = 1'b0; out_ready = 1'b1;
        a_in = '0; b_in = '0; exp_a = '0; exp_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_clr", acc_clr, 0);
        check_val("rst_valid", out_valid, 0);
        check_val("rst_alane", a_lane, 0);
        check_val("rst_blane", b_lane, 0);
        check_val("rst_c", c_out, 0);
        @(posedge clk); #1; rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            seq_a[i*DW +: DW] = DW'(i + 1);
            seq_b[i*DW +: DW] = DW'(i + 11);
        end
        run_op(seq_a, seq_b, 1'b0, 1'b0);
        run_op(rnd_mat(), rnd_mat(), 1'b1, 1'b0);
        run_op(rnd_mat(), rnd_mat(), 1'b0, 1'b1);

        // abort in FEED cyc1
        @(posedge clk); #1;
        exp_a = rnd_mat(); exp_b = rnd_mat();
        a_in = exp_a; b_in = exp_b; start = 1'b1;
        feed0 = cyc_no + 2;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_val("abort_alane", a_lane, 0);
        check_val("abort_blane", b_lane, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        exp_ops = 0; exp_stall = 0;
        @(negedge clk);
        check_val("abort_c", c_out, 0);
        run_op(rnd_mat(), rnd_mat(), 1'b0, 1'b0);

        // latency sweep on the COLLECT_LAT=3 and 10 instances
        @(posedge clk); #1;
        a_in = rnd_mat(); b_in = rnd_mat(); start_sw = 1'b1;
        feed0 = cyc_no + 2;
        @(posedge clk); #1; start_sw = 1'b0;
        v3 = -1; v10 = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (valid3 && v3 < 0) begin
                v3 = cyc_no;
                check_val("lat3_c", c3, exp_c(3));
            end
            if (valid10 && v10 < 0) begin
                v10 = cyc_no;
                check_val("lat10_c", c10, exp_c(10));
            end
        end
        check_val("lat3_rise", v3, feed0 + 6);
        check_val("lat10_rise", v10, feed0 + 13);

        check_val("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
